// File: rtl/muldiv_ctrl_pkg.sv
// Shared definitions for the multiply/divide sequencer and the main control unit.
package muldiv_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RUN   = 3'd1,
    S_WRITE = 3'd2,
    S_DONE  = 3'd3,
    S_DIVZ  = 3'd4
  } state_t;

  localparam logic [1:0] OP_MULT = 2'b00;
  localparam logic [1:0] OP_DIV  = 2'b01;
  localparam logic [1:0] OP_DIVM = 2'b10;
  localparam logic [1:0] OP_RSVD = 2'b11;

  localparam int CYCLES_DEF = 32;

  function automatic logic is_div(input logic [1:0] o);
    return (o == OP_DIV) || (o == OP_DIVM);
  endfunction

endpackage

// File: rtl/muldiv_ctrl.sv
// Sequencer for the iterative multiplier/divider: launch, count CYCLES iterations, write Hi/Lo, signal done.
// Divide-by-zero is caught at start and reported in one cycle without launching the unit.
module muldiv_ctrl
  import muldiv_ctrl_pkg::*;
#(
  parameter int CYCLES = CYCLES_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [1:0] op,
  input  logic       divisor_zero,
  output logic       unit_start,
  output logic       mult_sel,
  output logic       DivSrcA,
  output logic       DivSrcB,
  output logic       HiCtrl,
  output logic       LoCtrl,
  output logic       Hi_W,
  output logic       Lo_W,
  output logic       busy,
  output logic       done,
  output logic       div_zero
);

  localparam logic [5:0] LAST = 6'(CYCLES - 1);

  state_t     state;
  logic [5:0] cnt;
  logic [1:0] op_q;
  logic [1:0] sel_op;

  // Selects track the live op while idle so the datapath is already steered when start arrives.
  assign sel_op   = (state == S_IDLE) ? op : op_q;
  assign mult_sel = (sel_op == OP_MULT);
  assign HiCtrl   = mult_sel;
  assign LoCtrl   = mult_sel;
  assign DivSrcA  = (sel_op == OP_DIV);
  assign DivSrcB  = (sel_op == OP_DIVM);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      cnt        <= 6'd0;
      op_q       <= OP_MULT;
      unit_start <= 1'b0;
      Hi_W       <= 1'b0;
      Lo_W       <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      div_zero   <= 1'b0;
    end else begin
      unit_start <= 1'b0;
      Hi_W       <= 1'b0;
      Lo_W       <= 1'b0;
      done       <= 1'b0;
      div_zero   <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start && (op != OP_RSVD)) begin
            op_q <= op;
            cnt  <= 6'd0;
            busy <= 1'b1;
            if (is_div(op) && divisor_zero) begin
              state    <= S_DIVZ;
              div_zero <= 1'b1;
              done     <= 1'b1;
            end else begin
              state      <= S_RUN;
              unit_start <= 1'b1;
            end
          end
        end
        S_RUN: begin
          cnt <= cnt + 6'd1;
          if (cnt == LAST) begin
            state <= S_WRITE;
            Hi_W  <= 1'b1;
            Lo_W  <= 1'b1;
          end
        end
        S_WRITE: begin
          state <= S_DONE;
          done  <= 1'b1;
        end
        S_DONE: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
        S_DIVZ: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
